// File: rtl/paridade_serial_ctrl.sv
// Parity serial framer: accepts a word via valid/ready, computes its parity,
// and shifts out start bit, data LSB first, parity bit and stop bit on tx.
module paridade_serial_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD          = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             par,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic ODD_BIT = (ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_cyc_s;

  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    parity_of = (^w) ^ ODD_BIT;
  endfunction

  // Next-state sequencing; tx is derived from the next state so it stays aligned with it.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    last_cyc_s = (cyc_q == CW'(CLKS_PER_BIT - 1));
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = S_START;
          shreg_d    = in;
          par_d      = parity_of(in);
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          cyc_d      = '0;
          bit_d      = '0;
        end else begin
          cyc_d = '0;
          bit_d = '0;
        end
      end
      S_START: begin
        if (last_cyc_s) begin
          state_d = S_DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (last_cyc_s) begin
          cyc_d = '0;
          if (bit_q == BW'(WIDTH - 1)) begin
            state_d = S_PARITY;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (last_cyc_s) begin
          state_d = S_STOP;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        if (last_cyc_s) begin
          state_d    = S_IDLE;
          cyc_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        cyc_d      = '0;
        bit_d      = '0;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase

    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and returns the line to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign par      = par_q;
  assign done     = done_q;

endmodule
